// File: rtl/step2.sv
// PBVI backup stage 2: per (belief, action, obs) argmax over 16 projected alphas,
// then accumulates reward plus winning projections into the backed-up vector.
module step2 #(
  parameter int NB = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic [2:0][1:0][15:0][1:0][15:0]    gamma_i,
  input  logic [NB-1:0][1:0][15:0]            belief_i,
  input  logic [2:0][1:0][15:0]               reward_i,
  output logic                                busy_o,
  output logic                                en_step2_o,
  output logic [NB-1:0][2:0][1:0][15:0]       gamma_belief_action_o,
  output logic [NB-1:0][2:0][1:0][3:0]        best_index_o
);

  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t                             state_q;
  logic [2:0][1:0][15:0][1:0][15:0]   gamma_q;
  logic [NB-1:0][1:0][15:0]           bel_q;
  logic [2:0][1:0][15:0]              reward_q;
  logic [BW-1:0]                      b_q;
  logic [1:0]                         a_q;
  logic                               o_q;
  logic [3:0]                         j_q;
  logic [32:0]                        best_val_q;
  logic [3:0]                         best_idx_q;
  logic [1:0][17:0]                   acc_q;

  logic [31:0]                        prod0_d, prod1_d;
  logic [32:0]                        dot_d;
  logic [1:0][17:0]                   acc_d;
  logic [1:0][15:0]                   sat_d;

  assign prod0_d = 32'(gamma_q[a_q][o_q][j_q][0]) * 32'(bel_q[b_q][0]);
  assign prod1_d = 32'(gamma_q[a_q][o_q][j_q][1]) * 32'(bel_q[b_q][1]);
  assign dot_d   = {1'b0, prod0_d} + {1'b0, prod1_d};

  // First observation seeds the accumulator with the reward, the second adds onto it.
  always_comb begin
    acc_d = '0;
    sat_d = '0;
    for (int s = 0; s < 2; s++) begin
      acc_d[s] = (o_q ? acc_q[s] : {2'b00, reward_q[a_q][s]})
               + {2'b00, gamma_q[a_q][o_q][best_idx_q][s]};
      sat_d[s] = (acc_d[s] > 18'h0FFFF) ? 16'hFFFF : acc_d[s][15:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q               <= IDLE;
      busy_o                <= 1'b0;
      en_step2_o            <= 1'b0;
      gamma_belief_action_o <= '0;
      best_index_o          <= '0;
      gamma_q               <= '0;
      bel_q                 <= '0;
      reward_q              <= '0;
      b_q                   <= '0;
      a_q                   <= '0;
      o_q                   <= 1'b0;
      j_q                   <= '0;
      best_val_q            <= '0;
      best_idx_q            <= '0;
      acc_q                 <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          en_step2_o <= 1'b0;
          busy_o     <= 1'b0;
          state_q    <= IDLE;
          if (en_i) begin
            gamma_q  <= gamma_i;
            bel_q    <= belief_i;
            reward_q <= reward_i;
            b_q      <= '0;
            a_q      <= '0;
            o_q      <= 1'b0;
            j_q      <= '0;
            busy_o   <= 1'b1;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (j_q == 4'd0 || dot_d > best_val_q) begin
            best_val_q <= dot_d;
            best_idx_q <= j_q;
          end
          j_q <= j_q + 4'd1;
          if (j_q == 4'd15) state_q <= WRITE;
        end
        WRITE: begin
          acc_q                       <= acc_d;
          best_index_o[b_q][a_q][o_q] <= best_idx_q;
          j_q                         <= '0;
          state_q                     <= SCAN;
          if (!o_q) begin
            o_q <= 1'b1;
          end else begin
            for (int s = 0; s < 2; s++)
              gamma_belief_action_o[b_q][a_q][s] <= sat_d[s];
            o_q <= 1'b0;
            if (a_q != 2'd2) begin
              a_q <= a_q + 2'd1;
            end else begin
              a_q <= '0;
              if (b_q == BW'(NB - 1)) begin
                busy_o     <= 1'b0;
                en_step2_o <= 1'b1;
                state_q    <= DONE;
              end else begin
                b_q <= b_q + BW'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step2.sv
// Directed self-checking bench for step2 (NB = 4).
module tb_step2;
  localparam int NB = 4;

  logic                               clk = 1'b0;
  logic                               rst = 1'b0;
  logic                               en  = 1'b0;
  logic [2:0][1:0][15:0][1:0][15:0]   gamma;
  logic [NB-1:0][1:0][15:0]           belief;
  logic [2:0][1:0][15:0]              reward;
  logic                               busy;
  logic                               en_step2;
  logic [NB-1:0][2:0][1:0][15:0]      gba;
  logic [NB-1:0][2:0][1:0][3:0]       bidx;

  int passes = 0;
  int total  = 0;
  int cnt;

  step2 #(.NB(NB)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .en_i                  (en),
    .gamma_i               (gamma),
    .belief_i              (belief),
    .reward_i              (reward),
    .busy_o                (busy),
    .en_step2_o            (en_step2),
    .gamma_belief_action_o (gba),
    .best_index_o          (bidx)
  );

  always #5 clk = ~clk;

  task automatic randomize_inputs();
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 2; o++)
        for (int j = 0; j < 16; j++)
          for (int s = 0; s < 2; s++)
            gamma[a][o][j][s] = 16'($urandom);
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < 2; s++)
        belief[b][s] = 16'($urandom);
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++)
        reward[a][s] = 16'($urandom);
  endtask

  task automatic setup_single();
    gamma  = '0;
    gamma[0][0][5][0] = 16'd100;
    gamma[0][0][5][1] = 16'd100;
    reward = '0;
    for (int b = 0; b < NB; b++) begin
      belief[b][0] = 16'h8000;
      belief[b][1] = 16'h8000;
    end
  endtask

  // Pulses en so it is sampled at edge T; returns #1 into cycle T+1.
  task automatic pulse_en();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  // Waits (bounded) for en_step2; cnt is the cycle offset from T.
  task automatic wait_done();
    cnt = 1;
    while (!en_step2 && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    randomize_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gba !== '0 || bidx !== '0 || busy !== 1'b0 || en_step2 !== 1'b0)
      $display("FAIL reset_outputs: busy=%b done=%b gba_nz=%b idx_nz=%b required all 0",
               busy, en_step2, gba != '0, bidx != '0);
    else passes++;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (en_step2 !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL reset_idle: %0d active cycles, required 0", seen);
    else passes++;
  endtask

  task automatic test_single_winner();
    int bad;
    setup_single();
    pulse_en();
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy_start: busy=%b required 1", busy);
    else passes++;
    wait_done();
    total++;
    if (cnt != 409 || busy !== 1'b0)
      $display("FAIL single_latency: done at T+%0d busy=%b required T+409 busy=0", cnt, busy);
    else passes++;
    bad = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 3; a++)
        for (int s = 0; s < 2; s++) begin
          if (gba[b][a][s] !== ((a == 0) ? 16'd100 : 16'd0)) bad++;
          if (bidx[b][a][s] !== ((a == 0 && s == 0) ? 4'd5 : 4'd0)) bad++;
        end
    total++;
    if (bad != 0) $display("FAIL single_values: %0d wrong fields, required idx 5 / value 100", bad);
    else passes++;
    @(posedge clk); #1;
    total++;
    if (en_step2 !== 1'b0) $display("FAIL single_pulse_width: en_step2=%b required 0", en_step2);
    else passes++;
  endtask

  task automatic test_tie_strict();
    int bad;
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 2; o++)
        for (int j = 0; j < 16; j++) begin
          gamma[a][o][j][0] = 16'd7;
          gamma[a][o][j][1] = 16'd9;
        end
    reward = '0;
    belief[0] = {16'h8000, 16'h8000};
    belief[1] = {16'h0000, 16'h0001};
    belief[2] = {16'hFFFF, 16'h0000};
    belief[3] = {16'hFFFF, 16'hFFFF};
    pulse_en();
    wait_done();
    total++;
    if (cnt != 409) $display("FAIL tie_latency: done at T+%0d required T+409", cnt);
    else passes++;
    bad = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 3; a++) begin
        if (gba[b][a][0] !== 16'd14 || gba[b][a][1] !== 16'd18) bad++;
        if (bidx[b][a][0] !== 4'd0 || bidx[b][a][1] !== 4'd0) bad++;
      end
    total++;
    if (bad != 0) $display("FAIL tie_values: %0d wrong, required idx 0 and {14,18}", bad);
    else passes++;

    gamma[1][1][15][0] = 16'd8;
    pulse_en();
    wait_done();
    for (int b = 0; b < NB; b++) begin
      logic [3:0]  exp_idx;
      logic [15:0] exp_s0;
      exp_idx = (b == 2) ? 4'd0 : 4'd15;
      exp_s0  = (b == 2) ? 16'd14 : 16'd15;
      total++;
      if (bidx[b][1][1] !== exp_idx || gba[b][1][0] !== exp_s0 || gba[b][1][1] !== 16'd18)
        $display("FAIL strict_b%0d: idx=%0d v0=%0d v1=%0d required idx=%0d v0=%0d v1=18",
                 b, bidx[b][1][1], gba[b][1][0], gba[b][1][1], exp_idx, exp_s0);
      else passes++;
    end
  endtask

  task automatic test_saturation();
    int bad;
    gamma  = '1;
    reward = '1;
    belief[0] = {16'h1234, 16'h4321};
    pulse_en();
    wait_done();
    bad = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 3; a++)
        for (int s = 0; s < 2; s++)
          if (gba[b][a][s] !== 16'hFFFF) bad++;
    total++;
    if (bad != 0) $display("FAIL saturation: %0d values not 0xFFFF", bad);
    else passes++;
  endtask

  task automatic test_capture_isolation();
    int bad;
    setup_single();
    pulse_en();
    randomize_inputs();
    cnt = 1;
    while (!en_step2 && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      en = (cnt == 50);
      if (cnt % 7 == 0) randomize_inputs();
    end
    en = 1'b0;
    total++;
    if (cnt != 409) $display("FAIL iso_latency: done at T+%0d required T+409", cnt);
    else passes++;
    bad = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 3; a++)
        for (int s = 0; s < 2; s++) begin
          if (gba[b][a][s] !== ((a == 0) ? 16'd100 : 16'd0)) bad++;
          if (bidx[b][a][s] !== ((a == 0 && s == 0) ? 4'd5 : 4'd0)) bad++;
        end
    total++;
    if (bad != 0) $display("FAIL iso_values: %0d wrong fields vs single-winner result", bad);
    else passes++;
    en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    total++;
    if (busy !== 1'b1 || en_step2 !== 1'b0)
      $display("FAIL back_to_back: busy=%b done=%b required busy=1 done=0", busy, en_step2);
    else passes++;
  endtask

  task automatic test_reset_midrun();
    int seen;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    setup_single();
    pulse_en();
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    total++;
    if (gba !== '0 || bidx !== '0 || busy !== 1'b0 || en_step2 !== 1'b0 || dut.state_q !== 2'd0)
      $display("FAIL midrun_reset: busy=%b done=%b state=%0d outputs_nz=%b required all 0",
               busy, en_step2, dut.state_q, (gba != '0) || (bidx != '0));
    else passes++;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (en_step2 !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL midrun_no_done: %0d en_step2 cycles required 0", seen);
    else passes++;
    pulse_en();
    wait_done();
    total++;
    if (cnt != 409 || bidx[3][0][0] !== 4'd5 || gba[3][0][1] !== 16'd100)
      $display("FAIL midrun_restart: done at T+%0d idx=%0d v=%0d required T+409 idx=5 v=100",
               cnt, bidx[3][0][0], gba[3][0][1]);
    else passes++;
  endtask

  initial begin
    gamma  = '0;
    belief = '0;
    reward = '0;
    test_reset();
    test_single_winner();
    test_tie_strict();
    test_saturation();
    test_capture_isolation();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/step2.md
# step2

Second stage of the PBVI backup pipeline, directly downstream of `step1`. On the `step1` completion pulse it captures the full `gamma_intermediate_action_observation_alpha` projection set, the current belief points and the reward table. For every belief point and action, it then performs a sequential argmax over the 16 projected alpha vectors for each observation. It emits the per-(belief, action) backed-up vector (reward plus the sum of the winning projections) and the winning indices, consumed by the action-max stage.

## Interface

- `NB`, 4, number of belief points.
- `clk`  input  1  clock, all logic rising-edge.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  start pulse; driven by `step1.en_step1`.
- `gamma`  input  16 × [0:2][0:1][0:15][0:1]  projections `[action][obs][alpha][state]`, unsigned.
- `belief`  input  16 × [0:NB-1][0:1]  belief `[point][state]`, unsigned Q0.16.
- `reward`  input  16 × [0:2][0:1]  `[action][state]`, unsigned.
- `busy`  output  1  high while scanning.
- `en_step2`  output  1  one-cycle done pulse.
- `gamma_belief_action`  output  16 × [0:NB-1][0:2][0:1]  backed-up vector `[point][action][state]`.
- `best_index`  output  4 × [0:NB-1][0:2][0:1]  winning alpha `[point][action][obs]`.

## Operation

- **FSM states:** IDLE, SCAN, WRITE, DONE.
- **IDLE, or DONE, with `en` = 1:**
  - Capture `gamma`, `belief` and `reward` into internal registers.
  - Set b = a = o = j = 0 and go to SCAN.
- **Input sampling:** inputs are sampled only on the capture cycle. Later changes on the inputs do not affect the run.
- **`en` while in SCAN or WRITE:** ignored.
- **SCAN, one alpha per cycle:**
  - dot = g[a][o][j][0]·bel[b][0] + g[a][o][j][1]·bel[b][1]. Each product is 32 bits; the sum is 33 bits, unsigned, with no truncation.
  - At j = 0: load best_val = dot and best_idx = 0 unconditionally.
  - At j > 0: replace only if dot > best_val (strictly greater). On ties the lowest index wins.
  - After j = 15 has been compared, go to WRITE.
- **WRITE (one cycle):**
  - If o = 0, acc = reward[a][s] + g[a][o][best][s]. Otherwise acc = acc + g[a][o][best][s]. This is done per state s, with an 18-bit accumulator.
  - Write `best_index[b][a][o]` = best_idx.
  - If o = 1: write `gamma_belief_action[b][a][s]` = min(acc, 0xFFFF).
  - Advance o, then a, then b, and reset j to 0. Return to SCAN.
  - After (b = NB-1, a = 2, o = 1), go to DONE instead.
- **DONE (one cycle):**
  - Assert `en_step2`, then go to IDLE.
  - `en` is accepted in this cycle; it starts a new run the same way as in IDLE.
- **Output hold:** outputs keep their last written values until overwritten by a later run. They are not cleared at a new `en`.
- **Reset** (any state, including mid-run):
  - All outputs go to 0 and the FSM goes to IDLE.
  - No `en_step2` is emitted for an aborted run.

## Timing

- **Reset values:** `busy` = 0, `en_step2` = 0, all `gamma_belief_action` = 0, all `best_index` = 0.
- **Start:** `en` is sampled at edge T, giving capture and entry to SCAN. `busy` = 1 from cycle T+1.
- **Per (b, a, o):** 16 SCAN cycles plus 1 WRITE cycle = 17 cycles.
- **Total busy cycles:** NB·6·17. With NB = 4 this is 408 cycles, T+1 … T+408.
- **Completion:** `en_step2` = 1 and `busy` = 0 in cycle T+409. Outputs are final in that cycle.
- **Update visibility:** `best_index[b][a][o]` updates at the edge ending its WRITE cycle. `gamma_belief_action[b][a]` updates at the edge ending the o = 1 WRITE cycle.
- **Back-to-back:** `en` in the DONE cycle T+409 makes `busy` = 1 from T+410. The gap between runs is zero.

## Test plan

1. **Reset values.** Assert `rst` for 2 cycles with random inputs.
   - Required: all outputs 0.
   - Required: no `en_step2` within 500 cycles without `en`.
2. **Single winner.** All `gamma` = 0 except `gamma[0][0][5]` = {100, 100}. `belief[*]` = {0x8000, 0x8000}, `reward` = 0. Pulse `en`.
   - Required: `best_index[b][0][0]` = 5 and `best_index[b][0][1]` = 0.
   - Required: `gamma_belief_action[b][0]` = {100, 100}, and 0 for actions 1–2.
   - Required: `en_step2` exactly at T+409.
3. **Tie and strict compare.** All 16 alphas for every (a, o) = {7, 9}. Then repeat with `gamma[1][1][15][0]` = 8.
   - Required, first run: all indices 0 and outputs {14, 18}.
   - Required, second run: `best_index[b][1][1]` = 15 for any belief with nonzero state-0 weight. A belief of {0, 0xFFFF} must give index 0.
4. **Saturation.** `reward` = 0xFFFF and all `gamma` = 0xFFFF.
   - Required: every `gamma_belief_action` = 0xFFFF.
5. **Capture isolation.**
   - Scramble `gamma`, `belief` and `reward` from T+1. Required: results equal to scenario 2.
   - Re-pulse `en` at T+50. Required: ignored, `en_step2` still at T+409.
   - Pulse `en` at T+409. Required: `busy` high at T+410.
6. **Reset mid-run.** Assert `rst` at T+100.
   - Required: outputs 0, `busy` 0, FSM in IDLE, no `en_step2`.
   - A fresh `en` afterwards completes normally in 409 cycles.
